// File: rtl/seg595_fps_display.sv
// seg595_fps_display: binary -> BCD (sequential double dabble), 6-digit multiplexed 7-segment drive via two cascaded 74HC595.
// Optional feature macro: SEG_LEAD_ZERO_BLANK_EN (blank leading zero digits; digit 0 always shown).
module seg595_fps_display #(
    parameter int DATA_W    = 20,
    parameter int SCAN_DIV  = 10_000,
    parameter int SHIFT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic [5:0]        dot_en,
    input  logic              disp_en,
    output logic              SH_CP,
    output logic              ST_CP,
    output logic              DS
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DIV_W  = $clog2(SHIFT_DIV);
    localparam int ITER_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MAX_VAL  = DATA_W'(999_999);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SHIFT_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(SHIFT_DIV / 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

    logic              r_conv_busy;
    logic [ITER_W-1:0] r_iter;
    logic [DATA_W-1:0] r_bin;
    logic [23:0]       r_bcd_work;
    logic [23:0]       r_bcd;
    logic [23:0]       w_bcd_adj;
    logic [23:0]       w_bcd_next;
    logic [SCAN_W-1:0] r_scan;

    state_t            r_state, w_state_n;
    logic [13:0]       r_word, w_word_n;
    logic [3:0]        r_bit, w_bit_n;
    logic [DIV_W-1:0]  r_div, w_div_n;
    logic [2:0]        r_digit, w_digit_n;
    logic              r_sh, r_st, r_ds, w_sh_n, w_st_n, w_ds_n;

    logic [3:0]        w_nib;
    logic [6:0]        w_glyph;
    logic              w_blank;
    logic [7:0]        w_seg;
    logic [5:0]        w_sel;
    logic [13:0]       w_word;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        w_bcd_adj = '0;
        for (int n = 0; n < 6; n++) begin
            w_bcd_adj[4*n +: 4] = (r_bcd_work[4*n +: 4] >= 4'd5) ?
                                  r_bcd_work[4*n +: 4] + 4'd3 : r_bcd_work[4*n +: 4];
        end
        w_bcd_next = {w_bcd_adj[22:0], r_bin[DATA_W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_busy <= 1'b0;
            r_iter      <= '0;
            r_bin       <= '0;
            r_bcd_work  <= '0;
            r_bcd       <= '0;
        end else if (!r_conv_busy) begin
            r_bin       <= (din > MAX_VAL) ? MAX_VAL : din;
            r_bcd_work  <= '0;
            r_iter      <= '0;
            r_conv_busy <= 1'b1;
        end else begin
            r_bin      <= r_bin << 1;
            r_bcd_work <= w_bcd_next;
            r_iter     <= r_iter + ITER_W'(1);
            if (r_iter == ITER_W'(DATA_W - 1)) begin
                r_bcd       <= w_bcd_next;
                r_conv_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_scan <= '0;
        else if (r_scan == SCAN_W'(SCAN_DIV - 1)) r_scan <= '0;
        else                                     r_scan <= r_scan + SCAN_W'(1);
    end

    // Word for the current digit: {dp, g..a} active-low, then active-low one-hot select.
    always_comb begin
        w_nib = r_bcd[{r_digit, 2'b00} +: 4];
        case (w_nib)
            4'd0:    w_glyph = 7'h40;
            4'd1:    w_glyph = 7'h79;
            4'd2:    w_glyph = 7'h24;
            4'd3:    w_glyph = 7'h30;
            4'd4:    w_glyph = 7'h19;
            4'd5:    w_glyph = 7'h12;
            4'd6:    w_glyph = 7'h02;
            4'd7:    w_glyph = 7'h78;
            4'd8:    w_glyph = 7'h00;
            4'd9:    w_glyph = 7'h10;
            default: w_glyph = 7'h7F;
        endcase
`ifdef SEG_LEAD_ZERO_BLANK_EN
        w_blank = (r_digit != 3'd0) && ((r_bcd >> {r_digit, 2'b00}) == 24'd0);
`else
        w_blank = 1'b0;
`endif
        if (!disp_en)     w_seg = 8'hFF;
        else if (w_blank) w_seg = {~dot_en[r_digit], 7'h7F};
        else              w_seg = {~dot_en[r_digit], w_glyph};
        w_sel  = ~(6'b000001 << r_digit);
        w_word = {w_seg, w_sel};
    end

    // Outputs are registered from next-state values so SH_CP/ST_CP never glitch.
    always_comb begin
        w_state_n = r_state;
        w_word_n  = r_word;
        w_bit_n   = r_bit;
        w_div_n   = r_div;
        w_digit_n = r_digit;
        w_sh_n    = 1'b0;
        w_st_n    = 1'b0;
        w_ds_n    = r_ds;
        case (r_state)
            S_IDLE: begin
                if (r_scan == '0) w_state_n = S_LOAD;
            end
            S_LOAD: begin
                w_word_n  = w_word;
                w_bit_n   = 4'd13;
                w_div_n   = '0;
                w_ds_n    = w_word[13];
                w_digit_n = (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
                w_state_n = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_n = '0;
                    if (r_bit == 4'd0) begin
                        w_state_n = S_LATCH;
                        w_st_n    = 1'b1;
                    end else begin
                        w_bit_n = r_bit - 4'd1;
                        w_ds_n  = r_word[r_bit - 4'd1];
                    end
                end else begin
                    w_div_n = r_div + DIV_W'(1);
                    w_sh_n  = (w_div_n >= DIV_HALF);
                end
            end
            S_LATCH: begin
                if (r_div == DIV_LAST) begin
                    w_div_n   = '0;
                    w_state_n = S_IDLE;
                end else begin
                    w_div_n = r_div + DIV_W'(1);
                    w_st_n  = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_digit <= '0;
            r_sh    <= 1'b0;
            r_st    <= 1'b0;
            r_ds    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_word  <= w_word_n;
            r_bit   <= w_bit_n;
            r_div   <= w_div_n;
            r_digit <= w_digit_n;
            r_sh    <= w_sh_n;
            r_st    <= w_st_n;
            r_ds    <= w_ds_n;
        end
    end

    assign SH_CP = r_sh;
    assign ST_CP = r_st;
    assign DS    = r_ds;
endmodule

// File: tb/tb_seg595_fps_display.sv
// Bench for seg595_fps_display: a 74HC595 pair is emulated on the serial pins and every latched word is compared.
module tb_seg595_fps_display;
  localparam int DATA_W    = 20;
  localparam int SCAN_DIV  = 80;
  localparam int SHIFT_DIV = 4;
  localparam int W         = 14;
  localparam int SETTLE    = 2 * DATA_W + 4 + SCAN_DIV;
`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [5:0]        dot;
    logic              en;
    logic [5:0][7:0]   segs;
  } vec_t;

  // clock / reset
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [5:0]        dot_en = '0;
  logic              disp_en = 1'b1;
  logic              SH_CP, ST_CP, DS;

  always #5 clk = ~clk;

  seg595_fps_display #(.DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .SHIFT_DIV(SHIFT_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dot_en(dot_en), .disp_en(disp_en),
    .SH_CP(SH_CP), .ST_CP(ST_CP), .DS(DS)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // 595 emulation: shift DS on SH_CP rise, capture the 14-bit word on ST_CP rise
  logic         sh_prev = 1'b0, st_prev = 1'b0;
  logic [W-1:0] mon_sr = '0;
  int           mon_bits = 0;
  int           overlap = 0;
  logic [W-1:0] cap_q[$];
  int           bits_q[$];
  int           st_cyc_q[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sh_prev <= SH_CP;
    st_prev <= ST_CP;
    if (SH_CP && ST_CP) overlap <= overlap + 1;
    if (!rst_n) begin
      mon_bits <= 0;
    end else begin
      if (SH_CP && !sh_prev) begin
        mon_sr   <= {mon_sr[W-2:0], DS};
        mon_bits <= mon_bits + 1;
      end
      if (ST_CP && !st_prev) begin
        cap_q.push_back(mon_sr);
        bits_q.push_back(mon_bits);
        st_cyc_q.push_back(cyc);
        mon_bits <= 0;
      end
    end
  end

  always @(negedge clk)
    assert (!(SH_CP && ST_CP)) else $error("FAIL sh_st_overlap: SH_CP=%0b ST_CP=%0b", SH_CP, ST_CP);

  // reference model: decimal digits by plain arithmetic
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;  4: return 7'h19;
      5: return 7'h12;  6: return 7'h02;  7: return 7'h78;  8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] model_seg(input int v, input int d, input logic [5:0] dot, input logic en);
    int vv;
    logic [6:0] g;
    vv = (v > 999999) ? 999999 : v;
    if (!en) return 8'hFF;
    if (BLANK && d > 0 && vv < pow10(d)) g = 7'h7F;
    else g = glyph((vv / pow10(d)) % 10);
    return {~dot[d], g};
  endfunction

  function automatic logic [5:0] sel_of(input int d);
    logic [5:0] s;
    s = 6'h3F;
    s[d] = 1'b0;
    return s;
  endfunction

  function automatic int digit_of(input logic [W-1:0] w);
    for (int i = 0; i < 6; i++) if (!w[i]) return i;
    return 0;
  endfunction

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_either(input string name, input logic [W-1:0] act, input logic [W-1:0] a, input logic [W-1:0] b);
    n_checks++;
    if (act === a || act === b) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h or 0x%0h", name, act, a, b);
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    ok = (cap_q.size() >= n);
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_words: got %0d of %0d words within %0d cycles", cap_q.size(), n, budget);
    end
  endtask

  task automatic check_frame(input string name, input logic [5:0][7:0] segs);
    bit ok;
    int d0;
    logic [W-1:0] got;
    cap_q.delete(); bits_q.delete(); st_cyc_q.delete(); exp_q.delete();
    wait_words(6, 7 * SCAN_DIV, ok);
    if (!ok) return;
    d0 = digit_of(cap_q[0]);
    for (int k = 0; k < 6; k++) exp_q.push_back({segs[(d0 + k) % 6], sel_of((d0 + k) % 6)});
    for (int k = 0; k < 6; k++) begin
      got = cap_q.pop_front();
      check($sformatf("%s word%0d", name, k), got, exp_q.pop_front());
    end
  endtask

  vec_t tbl[$];

  initial begin
    bit ok;
    int k;
    logic [W-1:0] got;
    logic [5:0][7:0] segs;

    tbl.push_back('{20'd123456,  6'h00, 1'b1, 48'hF9A4B0999282});
    tbl.push_back('{20'hFFFFF,   6'h00, 1'b1, 48'h909090909090});
    tbl.push_back('{20'd1000000, 6'h00, 1'b1, 48'h909090909090});
    tbl.push_back('{20'd999998,  6'h00, 1'b1, 48'h909090909080});
    tbl.push_back('{20'd123456,  6'h2A, 1'b1, 48'h79A430991282});
    tbl.push_back('{20'd123456,  6'h3F, 1'b0, 48'hFFFFFFFFFFFF});
    tbl.push_back('{20'd654321,  6'h00, 1'b1, 48'h829299B0A4F9});
    tbl.push_back('{20'd987654,  6'h00, 1'b1, 48'h9080F8829299});
`ifdef SEG_LEAD_ZERO_BLANK_EN
    tbl.push_back('{20'd0,       6'h00, 1'b1, 48'hFFFFFFFFFFC0});
    tbl.push_back('{20'd42,      6'h00, 1'b1, 48'hFFFFFFFF99A4});
    tbl.push_back('{20'd42,      6'h02, 1'b1, 48'hFFFFFFFF19A4});
    tbl.push_back('{20'd1005,    6'h00, 1'b1, 48'hFFFFF9C0C092});
    tbl.push_back('{20'd7,       6'h20, 1'b1, 48'h7FFFFFFFFFF8});
`else
    tbl.push_back('{20'd0,       6'h00, 1'b1, 48'hC0C0C0C0C0C0});
    tbl.push_back('{20'd42,      6'h00, 1'b1, 48'hC0C0C0C099A4});
    tbl.push_back('{20'd42,      6'h02, 1'b1, 48'hC0C0C0C019A4});
    tbl.push_back('{20'd1005,    6'h00, 1'b1, 48'hC0C0F9C0C092});
    tbl.push_back('{20'd7,       6'h20, 1'b1, 48'h40C0C0C0C0F8});
`endif

    // reset state and first frame
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset SH_CP", SH_CP, 1'b0);
    check("reset ST_CP", ST_CP, 1'b0);
    check("reset DS", DS, 1'b0);
    rst_n = 1'b1;
    wait_words(3, 4 * SCAN_DIV, ok);
    if (ok) begin
      check("first word digit0", cap_q[0], 14'h303E);
      check("first word sh pulses", bits_q[0], 14);
      check("second word", cap_q[1], {model_seg(0, 1, 6'h00, 1'b1), sel_of(1)});
      check("third word", cap_q[2], {model_seg(0, 2, 6'h00, 1'b1), sel_of(2)});
      check("latch period 1", st_cyc_q[1] - st_cyc_q[0], SCAN_DIV);
      check("latch period 2", st_cyc_q[2] - st_cyc_q[1], SCAN_DIV);
    end

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      din = tbl[i].din; dot_en = tbl[i].dot; disp_en = tbl[i].en;
      repeat (SETTLE) @(negedge clk);
      check_frame($sformatf("tbl%0d din=%0d", i, tbl[i].din), tbl[i].segs);
    end

    // din changes during the shift of digit 2
    @(negedge clk);
    din = 20'd123456; dot_en = 6'h00; disp_en = 1'b1;
    repeat (SETTLE) @(negedge clk);
    cap_q.delete();
    ok = 1'b0; k = 0;
    while (!ok && k < 8 * SCAN_DIV) begin
      @(posedge clk);
      k++;
      if (cap_q.size() > 0) begin
        got = cap_q.pop_front();
        if (got[5:0] == 6'h3D) ok = 1'b1;
      end
    end
    if (!ok) begin n_checks++; $display("FAIL midshift: digit1 word not seen in %0d cycles", k); end
    k = 0;
    do begin @(negedge clk); k++; end while (!SH_CP && k < 2 * SCAN_DIV);
    din = 20'd654321;
    cap_q.delete();
    wait_words(12, 13 * SCAN_DIV, ok);
    if (ok) begin
      for (int j = 0; j < 12; j++) begin
        logic [W-1:0] w_old, w_new;
        int d;
        d = (2 + j) % 6;
        w_old = {model_seg(123456, d, 6'h00, 1'b1), sel_of(d)};
        w_new = {model_seg(654321, d, 6'h00, 1'b1), sel_of(d)};
        got = cap_q.pop_front();
        if (j == 0)     check("midshift word keeps old nibble", got, w_old);
        else if (j < 6) check_either($sformatf("midshift word%0d", j), got, w_old, w_new);
        else            check($sformatf("midshift word%0d new", j), got, w_new);
      end
    end

    // reset pulse in the middle of a shift
    k = 0;
    do begin @(negedge clk); k++; end while (!(SH_CP && DS) && k < 4 * SCAN_DIV);
    if (!(SH_CP && DS)) begin n_checks++; $display("FAIL rst_midshift: no shift with DS=1 in %0d cycles", k); end
    rst_n = 1'b0;
    #1;
    check("rst_midshift SH_CP", SH_CP, 1'b0);
    check("rst_midshift ST_CP", ST_CP, 1'b0);
    check("rst_midshift DS", DS, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete(); bits_q.delete();
    wait_words(1, 2 * SCAN_DIV, ok);
    if (ok) begin
      check("post-reset word digit0", cap_q[0], 14'h303E);
      check("post-reset sh pulses", bits_q[0], 14);
    end

    // randomized vectors against the model
    for (int r = 0; r < 16; r++) begin
      int v;
      case (r % 4)
        0:       v = int'($urandom_range(0, 999));
        1:       v = int'($urandom_range(0, 999999));
        2:       v = int'($urandom_range(999990, 1048575));
        default: v = int'($urandom_range(0, 99999));
      endcase
      @(negedge clk);
      din = v[DATA_W-1:0];
      dot_en = 6'($urandom_range(0, 63));
      disp_en = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < 6; d++) segs[d] = model_seg(v, d, dot_en, disp_en);
      repeat (SETTLE) @(negedge clk);
      check_frame($sformatf("rand%0d din=%0d", r, v), segs);
    end

    check("sh/st overlap cycles", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
